// File: rtl/ram_dp_param.sv
// Simple dual-port RAM: byte-enabled write port, pipelined read port with
// configurable latency and read-during-write policy, plus a zero-fill sequencer.

module ram_dp_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       sel,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module ram_dp_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [ADDR_W-1:0]     wrAddr,
  input  logic [DATA_W-1:0]     wrData,
  input  logic [DATA_W/8-1:0]   wrBe,
  input  logic                  rdEn,
  input  logic [ADDR_W-1:0]     rdAddr,
  output logic [DATA_W-1:0]     rdData,
  output logic                  rdValid,
  input  logic                  clrStart,
  output logic                  busy
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_ok, rd_ok, clr_we, collide;
  logic [NUM_LANES-1:0][7:0] old_word, new_word, rd_word;
  logic [RD_LAT:1]             vld_pipe;
  logic [RD_LAT:1][DATA_W-1:0] dat_pipe;

  assign busy    = (state_q == CLEAR);
  assign wr_ok   = wrEn & ~busy;
  assign rd_ok   = rdEn & ~busy;
  // A reset edge must not consume another clear slot, so the array is left
  // cleared exactly up to the last busy cycle before reset.
  assign clr_we  = busy & ~reset;
  assign collide = (RDW_MODE == 1) && wr_ok && rd_ok && (wrAddr == rdAddr);

  // Sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clrStart) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage: not reset; clear and user writes are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (wrBe[i]) mem[wrAddr][8*i +: 8] <= wrData[8*i +: 8];
    end
  end

  // Write-first bypass: per byte lane, take the incoming byte on a collision.
  assign old_word = mem[rdAddr];
  assign new_word = wrData;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ram_dp_lane u_lane (
      .old_byte (old_word[g]),
      .new_byte (new_word[g]),
      .sel      (collide & wrBe[g]),
      .merged   (rd_word[g])
    );
  end

  // Read pipeline: data stages only load on a valid, so rdData holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_ok;
      if (rd_ok) dat_pipe[1] <= rd_word;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign rdValid = vld_pipe[RD_LAT];
  assign rdData  = dat_pipe[RD_LAT];

endmodule
